// File: rtl/ifm_axis_buffer.sv
// AXI4-Stream ingress buffer for the IFM word parser: show-ahead FIFO plus per-job word accounting.
// Optional build macro TLAST_CHECK_EN adds the sticky tlast_err port.
module ifm_axis_buffer #(
  parameter int unsigned IN_W  = 512,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conv_start,
  input  logic [CNT_W-1:0] total_words,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             input_req,
  output logic [IN_W-1:0]  fm,
  output logic             fm_valid,
  output logic             init_word,
  output logic             busy,
  output logic             done,
  output logic             underflow_err
`ifdef TLAST_CHECK_EN
  ,
  output logic             tlast_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_tot;
  logic [CNT_W-1:0] r_words_in;
  logic [CNT_W-1:0] r_words_out;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [IN_W-1:0]  r_mem [DEPTH];
  logic             r_init;
  logic             r_done;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_busy;
  logic             w_push;
  logic             w_pop;
  logic             w_start;
  logic [CNT_W-1:0] w_in_next;
  logic [CNT_W-1:0] w_out_next;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_busy     = (r_state == PRIME) || (r_state == STREAM);
  assign w_in_next  = r_words_in + CNT_W'(1);
  assign w_out_next = r_words_out + CNT_W'(1);

  assign s_axis_tready = w_busy && !w_full && (r_words_in < r_tot);
  assign w_push        = s_axis_tvalid && s_axis_tready;
  assign w_pop         = w_busy && input_req && !w_empty;
  assign w_start       = (r_state == IDLE) && conv_start;

  assign fm            = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign fm_valid      = !w_empty;
  assign busy          = w_busy;
  assign done          = r_done;
  assign init_word     = r_init;
  assign underflow_err = r_underflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tot       <= '0;
      r_words_in  <= '0;
      r_words_out <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_init      <= 1'b0;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_init <= w_push && (r_state == PRIME);
      r_done <= (r_state == DONE);

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_start) begin
        r_tot       <= total_words;
        r_words_in  <= '0;
        r_words_out <= '0;
      end else begin
        if (w_push) r_words_in  <= w_in_next;
        if (w_pop)  r_words_out <= w_out_next;
      end

      if (w_start) begin
        r_underflow <= 1'b0;
      end else if (w_busy && input_req && w_empty) begin
        r_underflow <= 1'b1;
      end

      case (r_state)
        IDLE:    if (conv_start) r_state <= (total_words == '0) ? DONE : PRIME;
        PRIME:   if (w_push) r_state <= STREAM;
        STREAM:  if (w_pop && (w_out_next == r_tot)) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TLAST_CHECK_EN
  logic r_tlast_err;

  assign tlast_err = r_tlast_err;

  // tlast must mark exactly the job's final accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tlast_err <= 1'b0;
    end else if (w_start) begin
      r_tlast_err <= 1'b0;
    end else if (w_push && (s_axis_tlast != (w_in_next == r_tot))) begin
      r_tlast_err <= 1'b1;
    end
  end
`else
  logic w_unused_tlast;

  assign w_unused_tlast = s_axis_tlast;
`endif

endmodule

// File: doc/ifm_axis_buffer.md
Name: ifm_axis_buffer

Overview:
- Ingress stage directly upstream of the IFM word parser.
- Accepts 512-bit input-feature-map beats from an AXI4-Stream slave port and holds them in a small show-ahead FIFO.
- Presents the head word on fm and advances one word per input_req pulse from the parser.
- Generates init_word on the first word of a convolution job and counts words against a per-job total.

Parameters:
- IN_W, 512, AXIS data width and fm width.
- DEPTH, 4, FIFO depth in words; must be a power of two, minimum 2.
- CNT_W, 16, width of the job word counters and total_words.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- conv_start  input  1  one-cycle job start; latches total_words
- total_words  input  CNT_W  number of IN_W words in the job
- s_axis_tdata  input  IN_W  stream data
- s_axis_tvalid  input  1  stream valid
- s_axis_tready  output  1  stream ready
- s_axis_tlast  input  1  stream last beat
- input_req  input  1  parser request: pop the head word
- fm  output  IN_W  head word of the FIFO; 0 when empty
- fm_valid  output  1  FIFO non-empty
- init_word  output  1  one-cycle pulse when the job's first word reaches the head
- busy  output  1  job in progress
- done  output  1  one-cycle pulse when the last word is popped
- underflow_err  output  1  sticky: input_req seen while empty
- tlast_err  output  1  sticky tlast mismatch; only present with TLAST_CHECK_EN

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values: all outputs 0, FIFO pointers and counters 0, FSM in IDLE. Reset mid-job flushes the FIFO and drops the job without pulsing done.
- FSM states: IDLE, PRIME, STREAM, DONE.
  - IDLE: on conv_start, latch total_words into tot_r and clear both counters, underflow_err and tlast_err. Go to DONE if total_words==0, else to PRIME.
  - PRIME: wait for the first write. On that write, go to STREAM.
  - STREAM: go to DONE on the pop where words_out+1==tot_r.
  - DONE: pulse done for one cycle, then return to IDLE.
- busy is 1 in PRIME and STREAM. conv_start is ignored outside IDLE.
- s_axis_tready = (state==PRIME or STREAM) and FIFO not full and words_in<tot_r. It is registered-free (combinational from registers).
- Write: on tvalid&&tready, store tdata at wr_ptr and increment words_in. Pointers wrap modulo DEPTH, with an extra bit for full/empty.
- fm is mem[rd_ptr] (show-ahead). fm_valid = !empty. Head visible the cycle after the write edge (1-cycle write-to-fm latency).
- Pop: input_req && !empty at a rising edge advances rd_ptr and increments words_out. The next word is on fm in the cycle immediately after that edge.
- Simultaneous push and pop:
  - Both occur when the FIFO is non-empty; occupancy is unchanged.
  - When empty, the push is accepted and the pop is not performed.
- Underflow: input_req && empty while busy sets underflow_err. It stays set until the next accepted conv_start or reset. input_req in IDLE/DONE is ignored.
- init_word: one-cycle pulse in the cycle after the job's first write (word 0 at head). Exactly one pulse per job.
- Words beyond tot_r are never accepted (tready low). Leftover beats remain in the upstream stream.

Optional Feature:
- Macro: TLAST_CHECK_EN.
- Defined:
  - tlast_err port exists.
  - It is set sticky if an accepted beat has tlast==1 with words_in+1!=tot_r, or tlast==0 with words_in+1==tot_r.
  - It clears on accepted conv_start or rst.
  - Data flow is unaffected.
- Not defined: tlast_err port is absent and s_axis_tlast is ignored.

Test Plan:
- Basic job: conv_start with total_words=3; send beats A,B,C back-to-back; pulse input_req once per 8 cycles -> init_word one cycle after A is written; fm shows A, B, C in order; done pulses after the third pop; busy falls.
- Backpressure: total_words=8, DEPTH=4, no input_req -> tready drops after 4 writes; fm_valid=1, fm=word0; tready returns 1 the cycle after the first pop.
- Empty-path underflow: total_words=2; assert input_req before any beat -> underflow_err=1 and stays set; words_out unchanged; job still completes after 2 beats and 2 pops.
- Zero-length job: conv_start with total_words=0 -> tready stays 0; no init_word; done pulses 2 cycles after conv_start.
- Reset mid-job: rst asserted after 2 of 5 words -> next cycle all outputs 0, fm_valid=0, state IDLE; a new job with total_words=1 runs cleanly.
- TLAST_CHECK_EN: total_words=4 with tlast on beat 2 -> tlast_err=1 after the beat-2 edge; all 4 words are still delivered; without the macro no error port exists.
